// File: rtl/siso_shift_reg_pkg.sv
// Shared constants for the serial-in/serial-out delay line.
`timescale 1ns/1ps
package siso_shift_reg_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned DEPTH_MIN     = 1;
  localparam int unsigned DEPTH_MAX     = 64;

  // Fill counter must be able to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/siso_shift_reg_if.sv
// Stream and debug signals of the delay line, seen from driver (master) and delay line (slave).
`timescale 1ns/1ps
interface siso_shift_reg_if
  import siso_shift_reg_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
);

  logic             shift_en;
  logic             serial_in;
  logic             serial_out;
  logic [DEPTH-1:0] q;
  logic             primed;

  modport master (
    output shift_en,
    output serial_in,
    input  serial_out,
    input  q,
    input  primed
  );

  modport slave (
    input  shift_en,
    input  serial_in,
    output serial_out,
    output q,
    output primed
  );

endinterface

// File: rtl/siso_shift_reg.sv
// Fixed-latency 1-bit delay line with enable, parallel stage view and a primed flag.
`timescale 1ns/1ps
module siso_shift_reg
  import siso_shift_reg_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  siso_shift_reg_if.slave    bus
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  if ((DEPTH < DEPTH_MIN) || (DEPTH > DEPTH_MAX)) begin : g_bad_depth
    $error("siso_shift_reg: DEPTH=%0d outside legal range", DEPTH);
  end

  logic [DEPTH-1:0] r_q;
  logic [DEPTH-1:0] w_q_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_primed;

  // Newest bit enters stage 0; everything else moves one stage towards the output.
  always_comb begin
    w_q_next    = r_q;
    w_q_next[0] = bus.serial_in;
    for (int i = 1; i < int'(DEPTH); i++) begin
      w_q_next[i] = r_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (bus.shift_en) begin
      r_q <= w_q_next;
    end
  end

  // Saturating fill count; primed rises on the same edge as the DEPTH-th shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (bus.shift_en && (r_cnt != CNT_W'(DEPTH))) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(DEPTH - 1)) begin
        r_primed <= 1'b1;
      end
    end
  end

  assign bus.q          = r_q;
  assign bus.serial_out = r_q[DEPTH-1];
  assign bus.primed     = r_primed;

endmodule

// File: tb/tb_siso_shift_reg.sv
// Directed plus randomized bench for the delay line at DEPTH 4, 1 and 8.
`timescale 1ns/1ps
module tb_siso_shift_reg;

  logic clk;
  logic rst_n;

  siso_shift_reg_if #(.DEPTH(4)) b4 ();
  siso_shift_reg_if #(.DEPTH(1)) b1 ();
  siso_shift_reg_if #(.DEPTH(8)) b8 ();

  siso_shift_reg #(.DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  siso_shift_reg #(.DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  siso_shift_reg #(.DEPTH(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference history: every bit accepted since reset, newest at index 0.
  bit h4[$];
  bit h1[$];
  bit h8[$];

  function automatic logic [63:0] exp_q(input bit h[$], input int unsigned d);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < int'(d); i++) begin
      if (i < h.size()) v[i] = h[i];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e4, e1, e8;
    e4 = exp_q(h4, 4);
    e1 = exp_q(h1, 1);
    e8 = exp_q(h8, 8);
    check({tag, ".d4.q"},      64'(b4.q),          e4);
    check({tag, ".d4.so"},     64'(b4.serial_out), 64'(e4[3]));
    check({tag, ".d4.primed"}, 64'(b4.primed),     64'(h4.size() >= 4));
    check({tag, ".d1.q"},      64'(b1.q),          e1);
    check({tag, ".d1.so"},     64'(b1.serial_out), 64'(e1[0]));
    check({tag, ".d1.primed"}, 64'(b1.primed),     64'(h1.size() >= 1));
    check({tag, ".d8.q"},      64'(b8.q),          e8);
    check({tag, ".d8.so"},     64'(b8.serial_out), 64'(e8[7]));
    check({tag, ".d8.primed"}, 64'(b8.primed),     64'(h8.size() >= 8));
  endtask

  task automatic push(inout bit h[$], input logic b);
    h.push_front(bit'(b));
    if (h.size() > 64) void'(h.pop_back());
  endtask

  // One rising edge; the model accepts what each DUT sampled, then we settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (b4.shift_en) push(h4, b4.serial_in);
      if (b1.shift_en) push(h1, b1.serial_in);
      if (b8.shift_en) push(h8, b8.serial_in);
    end
    #1;
  endtask

  task automatic clear_model();
    h4.delete();
    h1.delete();
    h8.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  int unsigned sin_v [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
  int unsigned so_v  [8] = '{0, 0, 0, 1, 1, 0, 1, 0};
  int unsigned stl_so[4] = '{1, 0, 1, 0};
  logic [3:0]  stl_q [4] = '{4'b1010, 4'b0100, 4'b1000, 4'b0000};

  initial begin
    rst_n        = 1'b0;
    b4.shift_en  = 1'b1;
    b4.serial_in = 1'b1;
    b1.shift_en  = 1'b0;
    b1.serial_in = 1'b0;
    b8.shift_en  = 1'b0;
    b8.serial_in = 1'b0;

    // Reset held with live input.
    repeat (3) tick();
    check("rst.q",      64'(b4.q),          64'h0);
    check("rst.so",     64'(b4.serial_out), 64'h0);
    check("rst.primed", 64'(b4.primed),     64'h0);
    check_all("rst");

    // Release without enabled shifts: nothing moves.
    rst_n       = 1'b1;
    b4.shift_en = 1'b0;
    repeat (2) tick();
    check("idle.q",      64'(b4.q),      64'h0);
    check("idle.primed", 64'(b4.primed), 64'h0);
    check_all("idle");

    // Basic stream 1,1,0,1,0 then zeros.
    b4.shift_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b4.serial_in = sin_v[k][0];
      tick();
      check($sformatf("stream.so.e%0d", k + 1), 64'(b4.serial_out), 64'(so_v[k]));
      check($sformatf("stream.primed.e%0d", k + 1), 64'(b4.primed), 64'(k >= 3));
      if (k == 4) check("stream.q.e5", 64'(b4.q), 64'b1010);
      check_all("stream");
    end

    // Primed survives further edges with enable toggling.
    for (int k = 0; k < 20; k++) begin
      b4.shift_en  = 1'($urandom_range(0, 1));
      b4.serial_in = 1'($urandom_range(0, 1));
      tick();
      check("primed.hold", 64'(b4.primed), 64'h1);
      check_all("primed");
    end

    // Stall: shift 1,0,1, freeze for 5 edges, then drain.
    b4.shift_en = 1'b0;
    do_reset();
    b4.shift_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b4.serial_in = (k != 1);
      tick();
    end
    b4.shift_en  = 1'b0;
    b4.serial_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall.q",  64'(b4.q),          64'b0101);
      check("stall.so", 64'(b4.serial_out), 64'h0);
      check_all("stall");
    end
    b4.shift_en  = 1'b1;
    b4.serial_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain.so.e%0d", k + 1), 64'(b4.serial_out), 64'(stl_so[k]));
      check($sformatf("drain.q.e%0d", k + 1),  64'(b4.q),          64'(stl_q[k]));
      check_all("drain");
    end

    // Asynchronous reset between edges.
    do_reset();
    b4.serial_in = 1'b1;
    repeat (3) tick();
    check("async.pre.q", 64'(b4.q), 64'b0111);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("async.q",      64'(b4.q),          64'h0);
    check("async.so",     64'(b4.serial_out), 64'h0);
    check("async.primed", 64'(b4.primed),     64'h0);
    check_all("async");
    tick();
    rst_n = 1'b1;

    // Randomized streams on all three depths, scoreboarded every edge.
    for (int k = 0; k < 120; k++) begin
      b4.shift_en  = ($urandom_range(0, 3) != 0);
      b4.serial_in = 1'($urandom);
      b1.shift_en  = ($urandom_range(0, 3) != 0);
      b1.serial_in = 1'($urandom);
      b8.shift_en  = ($urandom_range(0, 3) != 0);
      b8.serial_in = 1'($urandom);
      tick();
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
